shift_sequencer_reg: RTL
========================

// Module: shift_sequencer_reg
//
// PURPOSE
// N-bit multi-mode shift register with a built-in burst sequencer.
// Supports parallel load, single-step shifts and an autonomous burst of K shifts
// started by one Start pulse, with Busy/Done handshake.
// Intended as the datapath register for shift-add multipliers and serial
// converters, so control FSMs no longer count shifts themselves.
//
// PARAMETERS
// N   8                Register width in bits (N >= 2).
// CW  $clog2(N+1)      Width of Count; must hold values 0..N.
//
// PORTS
// Clk        in   1    Rising-edge clock.
// Reset      in   1    Asynchronous, active-high reset.
// Load       in   1    Parallel load of Din; highest synchronous priority.
// Din        in   N    Parallel load data.
// Mode       in   2    00 logical right, 01 logical left, 10 rotate right, 11 arithmetic right.
// Shift_In   in   1    Serial fill bit for modes 00/01; ignored for 10/11.
// Shift_En   in   1    Single-step shift; honoured only in IDLE.
// Start      in   1    Begin burst of Count shifts; honoured only in IDLE.
// Count      in   CW   Burst length 0..N; values > N are treated as N.
// Dout       out  N    Register contents.
// Shift_Out  out  1    Bit that leaves on the next shift: Dout[0] for 00/10/11, Dout[N-1] for 01.
// Busy       out  1    High while state = RUN.
// Done       out  1    One-cycle pulse when a burst completes.
//
// BEHAVIOUR
// - Reset: Dout=0, state=IDLE, remaining=0, latched mode=00, Busy=0, Done=0. Takes effect immediately, with no clock required.
// - Shift ops for one step (S = Shift_In):
//   - 00: {S, Dout[N-1:1]}
//   - 01: {Dout[N-2:0], S}
//   - 10: {Dout[0], Dout[N-1:1]}
//   - 11: {Dout[N-1], Dout[N-1:1]}
// - FSM states: IDLE, RUN, DONE.
//   - IDLE, Load=1: Dout<=Din.
//   - IDLE, else Start=1 and Count>0: latch Mode, latch Shift_In source selection, set remaining<=min(Count,N); go to RUN. No shift on this edge.
//   - IDLE, else Start=1 and Count=0: go to DONE with no shift.
//   - IDLE, else Shift_En=1: one shift using the live Mode and Shift_In.
//   - IDLE, otherwise: hold.
//   - RUN, each edge: one shift using the latched Mode; the live Shift_In is sampled every cycle; remaining--. When remaining==1 on an edge, shift and go to DONE.
//   - DONE: Done=1 for exactly one cycle; the next edge returns to IDLE and Dout holds.
// - Latency: Start accepted at edge t with Count=k>0 -> shifts on edges t+1..t+k; Done high between edges t+k and t+k+1. Busy is high between edges t and t+k.
// - Load during RUN or DONE: Dout<=Din, burst aborted, state<=IDLE, no Done pulse.
// - Start and Shift_En while not IDLE: ignored. Start and Shift_En together in IDLE: Start wins.
// - Mode changes during RUN do not affect the burst, but do update Shift_Out.
// - Rotate right for N steps returns the original value.
// - Arithmetic right for N steps yields all copies of the original MSB.
// - Reset asserted mid-burst: immediate return to reset values; no Done pulse.
//
// TESTING
// 1. N=8. Load 8'hB4, Mode=00, Shift_In=1, Shift_En for 1 cycle -> Dout=8'hDA, Shift_Out=0.
// 2. Load 8'h81, Mode=10, Start with Count=3 -> Dout 8'hC0, 8'h60, 8'h30 on successive edges. Busy high 3 cycles; Done pulses once on the 4th cycle.
// 3. Load 8'h90, Mode=11, Start with Count=8 -> Dout=8'hFF at Done. Same test with Count=15 -> treated as 8, same result.
// 4. Start with Count=0 -> no Dout change; Done high in the cycle after Start; Busy never asserted.
// 5. Load 8'h01, Mode=01, Shift_In=0, Start Count=5; after 2 shifts assert Load with Din=8'h3C -> Dout=8'h3C, state IDLE, Done never pulses. Next, Shift_En -> Dout=8'h78.
// 6. Assert Reset asynchronously between clock edges mid-burst -> Dout=0 and Busy=0 before the next edge. Reset released: Start and Shift_En idle -> Dout stays 0.

Source files
------------

// File: rtl/shift_sequencer_reg.sv
// N-bit multi-mode shift register with a built-in burst sequencer.
// One Start pulse runs Count shifts on its own and reports with Busy and Done.
module shift_sequencer_reg #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Load,
  input  logic [N-1:0]  Din,
  input  logic [1:0]    Mode,
  input  logic          Shift_In,
  input  logic          Shift_En,
  input  logic          Start,
  input  logic [CW-1:0] Count,
  output logic [N-1:0]  Dout,
  output logic          Shift_Out,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  dout_q, dout_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] count_sat;

  function automatic logic [N-1:0] shift_op(input logic [N-1:0] v, input logic [1:0] m,
                                            input logic s);
    logic [N-1:0] r;
    case (m)
      2'b00:   r = {s, v[N-1:1]};
      2'b01:   r = {v[N-2:0], s};
      2'b10:   r = {v[0], v[N-1:1]};
      default: r = {v[N-1], v[N-1:1]};
    endcase
    return r;
  endfunction

  // Burst lengths beyond the register width saturate at N.
  assign count_sat = (Count > CW'(N)) ? CW'(N) : Count;

  always_comb begin
    state_d     = state_q;
    dout_d      = dout_q;
    remaining_d = remaining_q;
    mode_d      = mode_q;
    case (state_q)
      StIdle: begin
        if (Load) begin
          dout_d = Din;
        end else if (Start) begin
          if (count_sat != '0) begin
            mode_d      = Mode;
            remaining_d = count_sat;
            state_d     = StRun;
          end else begin
            state_d = StDone;
          end
        end else if (Shift_En) begin
          dout_d = shift_op(dout_q, Mode, Shift_In);
        end
      end
      StRun: begin
        if (Load) begin
          // Abort: no Done pulse for a burst cut short by a load.
          dout_d      = Din;
          remaining_d = '0;
          state_d     = StIdle;
        end else begin
          dout_d      = shift_op(dout_q, mode_q, Shift_In);
          remaining_d = remaining_q - CW'(1);
          if (remaining_q == CW'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (Load) begin
          dout_d = Din;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      dout_q      <= '0;
      remaining_q <= '0;
      mode_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      dout_q      <= dout_d;
      remaining_q <= remaining_d;
      mode_q      <= mode_d;
    end
  end

  // Shift_Out follows the live Mode, even mid-burst.
  assign Dout      = dout_q;
  assign Shift_Out = (Mode == 2'b01) ? dout_q[N-1] : dout_q[0];
  assign Busy      = (state_q == StRun);
  assign Done      = (state_q == StDone);

endmodule
